// File: rtl/bytecode_pkg.sv
// Shared types and constants for the bytecode fetch path and decoder.
// Pure declarations, no latency.
// No flow control lives here.
package bytecode_pkg;

    localparam int OPCODE_W = 8;
    localparam int LEN_W    = 2;

    typedef enum logic [2:0] {
        IDLE,
        OP_ADDR,
        OP_DATA,
        ARG_ADDR,
        ARG_DATA,
        ISSUE,
        FAULT
    } state_t;

    localparam logic [OPCODE_W-1:0] NOP      = 8'h00;
    localparam logic [OPCODE_W-1:0] ICONST_0 = 8'h03;
    localparam logic [OPCODE_W-1:0] BIPUSH   = 8'h10;
    localparam logic [OPCODE_W-1:0] SIPUSH   = 8'h11;
    localparam logic [OPCODE_W-1:0] ILOAD    = 8'h15;
    localparam logic [OPCODE_W-1:0] IINC     = 8'h84;
    localparam logic [OPCODE_W-1:0] IFEQ     = 8'h99;
    localparam logic [OPCODE_W-1:0] GOTO     = 8'hA7;
    localparam logic [OPCODE_W-1:0] IRETURN  = 8'hAC;
    localparam logic [OPCODE_W-1:0] RETURN   = 8'hB1;

    typedef struct packed {
        logic             illegal;
        logic [LEN_W-1:0] len;
    } len_code_t;

    function automatic len_code_t legal_len(input logic [LEN_W-1:0] n);
        return '{illegal: 1'b0, len: n};
    endfunction

endpackage

// File: rtl/opcode_length_lut.sv
// Opcode to operand-byte count, with an illegal flag for unassigned opcodes.
// Combinational, zero latency.
// No flow control.
module opcode_length_lut
    import bytecode_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output len_code_t           code
);

    always_comb begin
        code = '{illegal: 1'b1, len: '0};
        if (opcode <= 8'h0F
            || (opcode >= 8'h1A && opcode <= 8'h35)
            || (opcode >= 8'h3B && opcode <= 8'h98 && opcode != IINC)
            || (opcode >= IRETURN && opcode <= RETURN)) begin
            code = legal_len(2'd0);
        end else if (opcode == BIPUSH
            || (opcode >= ILOAD && opcode <= 8'h19)
            || (opcode >= 8'h36 && opcode <= 8'h3A)) begin
            code = legal_len(2'd1);
        end else if (opcode == SIPUSH || opcode == IINC
            || (opcode >= IFEQ && opcode <= GOTO)) begin
            code = legal_len(2'd2);
        end
    end

endmodule

// File: rtl/bytecode_fetch_sequencer.sv
// Fetches opcode plus operand bytes from a synchronous ROM and issues one instruction word.
// 3 + 2n cycles per instruction of n operand bytes with ready held high.
// Holds the instruction with start high until ready; a branch drops it and refetches.
module bytecode_fetch_sequencer
    import bytecode_pkg::*;
#(
    parameter int BYTE_W       = 8,
    parameter int MEM_SIZE     = 8,
    parameter int MAX_OPERANDS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    output logic [MEM_SIZE-1:0]            rom_address,
    input  logic [BYTE_W-1:0]              data_from_rom,
    output logic                           start_for_decoder,
    input  logic                           ready_from_decoder,
    output logic [BYTE_W-1:0]              opcode_for_decoder,
    output logic [MAX_OPERANDS*BYTE_W-1:0] operands_for_decoder,
    output logic [1:0]                     operand_count,
    output logic [MEM_SIZE-1:0]            instr_pc,
    input  logic                           branch_valid,
    input  logic [MEM_SIZE-1:0]            branch_target,
    output logic                           busy,
    output logic                           fault
);

    state_t              state, state_nxt;
    logic [MEM_SIZE-1:0] pc;
    logic                take_branch;
    logic                latch_op;
    logic                shift_arg;
    logic [1:0]          count_nxt;
    logic [OPCODE_W-1:0] lut_opcode;
    len_code_t           len_code;

    // The opcode is still on the ROM bus in OP_DATA; afterwards use the latched copy.
    assign lut_opcode = (state == OP_DATA) ? data_from_rom : opcode_for_decoder;

    opcode_length_lut u_len_lut (
        .opcode (lut_opcode),
        .code   (len_code)
    );

    assign rom_address = pc;
    assign count_nxt   = operand_count + 2'd1;

    always_comb begin
        state_nxt         = state;
        take_branch       = 1'b0;
        latch_op          = 1'b0;
        shift_arg         = 1'b0;
        start_for_decoder = (state == ISSUE);
        fault             = (state == FAULT);
        busy              = (state != IDLE) && (state != FAULT);
        if (busy && branch_valid) begin
            take_branch = 1'b1;
            state_nxt   = OP_ADDR;
        end else begin
            case (state)
                IDLE:     if (run) state_nxt = OP_ADDR;
                OP_ADDR:  state_nxt = OP_DATA;
                OP_DATA: begin
                    latch_op = 1'b1;
                    if (len_code.illegal)        state_nxt = FAULT;
                    else if (len_code.len == '0) state_nxt = ISSUE;
                    else                         state_nxt = ARG_ADDR;
                end
                ARG_ADDR: state_nxt = ARG_DATA;
                ARG_DATA: begin
                    shift_arg = 1'b1;
                    state_nxt = (count_nxt == len_code.len) ? ISSUE : ARG_ADDR;
                end
                ISSUE:    if (ready_from_decoder) state_nxt = run ? OP_ADDR : IDLE;
                FAULT:    state_nxt = FAULT;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            pc                   <= '0;
            opcode_for_decoder   <= '0;
            operands_for_decoder <= '0;
            operand_count        <= '0;
            instr_pc             <= '0;
        end else begin
            state <= state_nxt;
            if (take_branch)
                pc <= branch_target;
            else if (latch_op || shift_arg)
                pc <= pc + MEM_SIZE'(1);
            if (latch_op) begin
                opcode_for_decoder   <= data_from_rom;
                instr_pc             <= pc;
                operands_for_decoder <= '0;
                operand_count        <= '0;
            end
            if (shift_arg) begin
                operands_for_decoder <= {operands_for_decoder[(MAX_OPERANDS-1)*BYTE_W-1:0],
                                         data_from_rom};
                operand_count        <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bytecode_fetch_sequencer.sv
// Bench for bytecode_fetch_sequencer: directed scenarios plus random ROM/handshake/branch traffic
// compared each cycle against a transaction-level timing model.
module tb_bytecode_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, ready, bv;
    logic [7:0]  bt;
    logic [7:0]  rom_address, rom_q;
    logic        start, busy, fault;
    logic [7:0]  opcode, instr_pc;
    logic [15:0] operands;
    logic [1:0]  operand_count;

    logic [7:0]  rom [256];
    int          ref_len [256];

    always #5 clk = ~clk;
    always @(posedge clk) rom_q <= rom[rom_address];

    bytecode_fetch_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .run                  (run),
        .rom_address          (rom_address),
        .data_from_rom        (rom_q),
        .start_for_decoder    (start),
        .ready_from_decoder   (ready),
        .opcode_for_decoder   (opcode),
        .operands_for_decoder (operands),
        .operand_count        (operand_count),
        .instr_pc             (instr_pc),
        .branch_valid         (bv),
        .branch_target        (bt),
        .busy                 (busy),
        .fault                (fault)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: an instruction started at address P with n operands shows start after
    // 2+2n cycles; the address seen k cycles in is P + k/2.
    localparam int M_IDLE = 0, M_FETCH = 1, M_ISSUE = 2, M_FAULT = 3;
    int          m_mode = M_IDLE;
    int          m_k = 0, m_n = 0;
    logic [7:0]  m_p = 8'h00, m_pc = 8'h00, m_op = 8'h00, m_ipc = 8'h00;
    logic [15:0] m_ops = 16'h0;
    int          exp_x = 0, obs_x = 0;

    task automatic set_range(input int lo, input int hi, input int n);
        for (int i = lo; i <= hi; i++) ref_len[i] = n;
    endtask

    task automatic begin_fetch(input logic [7:0] p);
        m_mode = M_FETCH;
        m_p    = p;
        m_pc   = p;
        m_k    = 0;
    endtask

    task automatic model_step(input logic rst, input logic r, input logic rdy,
                              input logic b, input logic [7:0] t);
        logic [7:0] a1, a2;
        if (rst) begin
            m_mode = M_IDLE; m_pc = 8'h00; m_op = 8'h00; m_ipc = 8'h00;
            return;
        end
        case (m_mode)
            M_IDLE: if (r) begin_fetch(m_pc);
            M_FETCH: begin
                if (b) begin_fetch(t);
                else begin
                    m_k++;
                    if (m_k == 2) begin
                        m_op  = rom[m_p];
                        m_ipc = m_p;
                        m_n   = ref_len[m_op];
                        if (m_n < 0) m_mode = M_FAULT;
                    end
                    m_pc = m_p + 8'(m_k / 2);
                    if (m_mode == M_FETCH && m_k == 2 + 2 * m_n) begin
                        a1 = m_p + 8'd1;
                        a2 = m_p + 8'd2;
                        m_mode = M_ISSUE;
                        m_ops  = (m_n == 0) ? 16'h0 :
                                 (m_n == 1) ? {8'h00, rom[a1]} : {rom[a1], rom[a2]};
                    end
                end
            end
            M_ISSUE: begin
                if (rdy) exp_x++;
                if (b) begin_fetch(t);
                else if (rdy) begin
                    if (r) begin_fetch(m_pc);
                    else   m_mode = M_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        chk("start", start, m_mode == M_ISSUE);
        chk("busy", busy, m_mode == M_FETCH || m_mode == M_ISSUE);
        chk("fault", fault, m_mode == M_FAULT);
        chk("rom_address", rom_address, m_pc);
        chk("opcode", opcode, m_op);
        chk("instr_pc", instr_pc, m_ipc);
        if (m_mode == M_ISSUE) begin
            chk("operands", operands, m_ops);
            chk("operand_count", operand_count, m_n);
        end
    endtask

    task automatic cycle(input logic rst, input logic r, input logic rdy,
                         input logic b, input logic [7:0] t);
        reset = rst; run = r; ready = rdy; bv = b; bt = t;
        if (!rst && start && rdy) obs_x++;
        @(posedge clk);
        model_step(rst, r, rdy, b, t);
        #1;
        compare();
    endtask

    task automatic wait_start(input logic r, input logic rdy, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, r, rdy, 1'b0, 8'h00);
            if (start) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic load_and_reset(input logic [7:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    int lat, x0;
    logic [7:0] hold_addr;

    initial begin
        reset = 1'b1; run = 1'b0; ready = 1'b0; bv = 1'b0; bt = 8'h00;
        for (int i = 0; i < 256; i++) ref_len[i] = -1;
        set_range('h00, 'h0F, 0); set_range('h10, 'h10, 1); set_range('h11, 'h11, 2);
        set_range('h15, 'h19, 1); set_range('h1A, 'h35, 0); set_range('h36, 'h3A, 1);
        set_range('h3B, 'h98, 0); set_range('h84, 'h84, 2); set_range('h99, 'hA7, 2);
        set_range('hAC, 'hB1, 0);

        // 1: zero-operand opcode
        load_and_reset(8'h00);
        rom[0] = 8'h03;
        cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0);
        chk("rst_operands", operands, 16'h0);
        chk("rst_count", operand_count, 2'd0);
        chk("rst_start", start, 1'b0);
        wait_start(1, 1, lat);
        chk("t1_latency", lat, 3);
        chk("t1_opcode", opcode, 8'h03);
        chk("t1_count", operand_count, 2'd0);
        chk("t1_instr_pc", instr_pc, 8'h00);
        cycle(0, 1, 1, 0, 0);
        chk("t1_next_addr", rom_address, 8'h01);

        // 2: one operand
        load_and_reset(8'h00);
        rom[0] = 8'h10; rom[1] = 8'h7F;
        cycle(1, 0, 0, 0, 0);
        wait_start(1, 1, lat);
        chk("t2_latency", lat, 5);
        chk("t2_operands", operands, 16'h007F);
        chk("t2_count", operand_count, 2'd1);
        cycle(0, 1, 1, 0, 0);
        chk("t2_next_addr", rom_address, 8'h02);

        // 3: two operands with decoder stall
        load_and_reset(8'h00);
        rom[0] = 8'h11; rom[1] = 8'h12; rom[2] = 8'h34;
        cycle(1, 0, 0, 0, 0);
        wait_start(1, 0, lat);
        chk("t3_latency", lat, 7);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 0, 0);
            chk("t3_start_held", start, 1'b1);
            chk("t3_operands_held", operands, 16'h1234);
        end
        x0 = obs_x;
        cycle(0, 0, 1, 0, 0);
        chk("t3_start_drop", start, 1'b0);
        cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);
        chk("t3_one_transfer", obs_x - x0, 1);

        // 4: branch in the handshake cycle
        load_and_reset(8'h00);
        rom[0] = 8'h99; rom[1] = 8'h00; rom[2] = 8'h05;
        cycle(1, 0, 0, 0, 0);
        wait_start(1, 1, lat);
        chk("t4_operands", operands, 16'h0005);
        x0 = obs_x;
        cycle(0, 1, 1, 1, 8'h40);
        chk("t4_transfer", obs_x - x0, 1);
        chk("t4_redirect", rom_address, 8'h40);

        // 5: illegal opcode trap
        load_and_reset(8'h00);
        rom[5] = 8'hCA;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 40 && !fault; i++) cycle(0, 1, 1, 0, 0);
        chk("t5_fault", fault, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_instr_pc", instr_pc, 8'h05);
        hold_addr = rom_address;
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, 8'h10);
        chk("t5_fault_sticky", fault, 1'b1);
        chk("t5_no_fetch", rom_address, hold_addr);
        cycle(1, 1, 1, 0, 0);
        chk("t5_reset_fault", fault, 1'b0);
        chk("t5_reset_pc", rom_address, 8'h00);

        // 6: operand across the address wrap
        load_and_reset(8'h00);
        rom[8'hFF] = 8'h10; rom[0] = 8'h22;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 1, 8'hFF);
        wait_start(1, 1, lat);
        chk("t6_opcode", opcode, 8'h10);
        chk("t6_operands", operands, 16'h0022);
        chk("t6_instr_pc", instr_pc, 8'hFF);
        cycle(0, 1, 1, 0, 0);
        chk("t6_next_addr", rom_address, 8'h01);

        // random traffic
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 99) < 4) rom[i] = 8'hB2 + 8'($urandom_range(0, 60));
            else begin
                logic [7:0] v;
                v = 8'($urandom);
                while (ref_len[v] < 0) v = 8'($urandom);
                rom[i] = v;
            end
        end
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic rr;
            rr = ($urandom_range(0, 199) == 0) || (m_mode == M_FAULT && $urandom_range(0, 9) == 0);
            cycle(rr, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 29) == 0), 8'($urandom));
        end
        chk("xfer_total", obs_x, exp_x);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
